alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 8-bit ALU between two requesters, such as a register-file micro-sequencer and a debug/test port. It accepts one operation at a time over a valid/ready request handshake, drives the ALU's A, B and FunSel inputs, waits for the ALU's clocked Flags to settle, and captures the result and flags. It then returns them to the winning requester over a valid/ready response handshake. The block sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- DATA_W, 8, operand/result width (matches ALU)
- FLAG_W, 4, ALU flag width
- clk  in  1  rising-edge clock, shared with the ALU clk
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_a  in  2×DATA_W  per-port operand A, packed, port 1 in the upper half
- req_b  in  2×DATA_W  per-port operand B
- req_funsel  in  2×4  per-port ALU function select
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_result  out  DATA_W  captured OutALU, shared by both ports
- rsp_flags  out  FLAG_W  captured Flags, shared by both ports
- alu_a, alu_b  out  DATA_W  to ALU A and B
- alu_funsel  out  4  to ALU FunSel
- alu_out  in  DATA_W  from ALU OutALU (combinational)
- alu_flags  in  FLAG_W  from ALU Flags (registered on clk)
- busy  out  1  high in any state except IDLE

## Operation
- **States:**
  - IDLE: arbitrate.
  - ISSUE: ALU inputs driven; ALU flags register at the end of this cycle.
  - CAPTURE: sample alu_out and alu_flags into rsp_result and rsp_flags.
  - RESP: hold rsp_valid for the granted port.
- **Transitions:**
  - IDLE→ISSUE on any req_valid & req_ready.
  - ISSUE→CAPTURE unconditionally.
  - CAPTURE→RESP unconditionally.
  - RESP→IDLE on rsp_valid[g] & rsp_ready[g].
- **Arbitration:**
  - Grant is computed only in IDLE.
  - req_ready[i] = (state==IDLE) & grant[i], so at most one bit is ever set.
  - With one port valid, that port wins.
  - With both ports valid, port prio wins.
  - After each accept, prio is set to the other port (round-robin).
- **Accept:** the operands and FunSel of the winning port are latched into alu_a, alu_b and alu_funsel, and the grant index g is latched.
- **ALU input hold:** the ALU inputs hold their values until the next accept, so alu_out remains valid through CAPTURE.
- **FunSel pass-through:** FunSel is passed through unchecked. Undefined codes (0000–0011, 1001) complete normally with whatever the ALU returns.
- **Response stability:** rsp_result and rsp_flags stay stable from CAPTURE until the next capture. Only rsp_valid[g] is asserted; the other bit stays 0.
- **Requester rule:** a requester must hold req_* stable while req_valid is high and req_ready is low.

## Timing
- **Reset values:** state=IDLE, prio=0, req_ready=00, rsp_valid=00, busy=0, alu_a=alu_b=0, alu_funsel=0000, rsp_result=0, rsp_flags=0.
- **Latency and throughput:**
  - Accept edge at cycle n, ISSUE during cycle n+1, CAPTURE during cycle n+2.
  - rsp_valid rises at the start of cycle n+3.
  - Minimum request-to-request period is 4 cycles (3 cycles plus a 1-cycle RESP when rsp_ready is already high).
- **Back-pressure:**
  - RESP holds indefinitely while rsp_ready[g] is low.
  - req_ready stays 00 throughout ISSUE, CAPTURE and RESP.
- **Simultaneous events:**
  - A new req_valid arriving during RESP is not accepted in the same cycle as the response handshake. It is accepted at the earliest in the following IDLE cycle.
  - rsp_ready on the non-granted port is ignored.
- **Reset mid-operation:** all state returns immediately to reset values and any in-flight operation is dropped with no response. The ALU's own Flags register is not reset by this block.
- **Width:** no arithmetic in this block; only the ALU computes.

## Structure
- **Shared include `alu_defs.vh`:**
  - FunSel constants: ADD 0100, SUB 0101, CMP 0110, AND 0111, OR 1000, XOR 1010, LSL 1011, LSR 1100, ASL 1101, ASR 1110, CSR 1111.
  - 2-bit state encodings: IDLE 00, ISSUE 01, CAPTURE 10, RESP 11.
  - DATA_W and FLAG_W defaults.
- **Sub-module `rr_arb2`:** combinational grant from (valid[1:0], prio), one-hot output.
- **Top:** alu_arbiter holds the FSM, the prio flop and the capture registers. It does not instantiate the ALU; the testbench or top level connects the ALU.

## Test plan
- **Single request:** port 0 sends ADD A=0x33, B=0x0F with rsp_ready=1.
  - rsp_valid[0] rises 3 cycles after the accept.
  - rsp_result=0x42; rsp_flags equals the ALU Flags after that edge.
  - busy is high for 3 cycles.
- **Contention:** both ports request at once after reset (prio=0).
  - Port 0 runs AND 0xAA,0xF0 and gets 0xA0.
  - Port 1 then runs OR 0xAA,0xF0 and gets 0xFA.
  - prio alternates on each accept.
- **Fairness:** both ports held continuously valid for 6 operations → grants alternate 0,1,0,1,0,1; port 1 performs XOR 0xAA,0xF0 and each result is 0x5A.
- **Back-pressure:** rsp_ready[1]=0 for 5 cycles during a LSL of 0x33.
  - rsp_valid[1] and rsp_result=0x66 are held stable; req_ready=00.
  - The response completes once rsp_ready[1] rises.
- **Reset mid-operation:** rst_n is asserted low during CAPTURE.
  - All outputs return to reset values asynchronously and no rsp_valid appears.
  - After release, a SUB 0x07,0xFA on port 1 completes with result 0x0D.
- **Stale-operand check:** after a CSR of 0x80 completes, alu_a=0x80 and alu_funsel=1111 are held with busy=0 until the next accept.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: default widths, ALU FunSel
// codes and the sequencer state encoding.
package alu_arbiter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FLAG_W = 4;
  localparam int FUNSEL_W   = 4;

  localparam logic [FUNSEL_W-1:0] FS_ADD = 4'b0100;
  localparam logic [FUNSEL_W-1:0] FS_SUB = 4'b0101;
  localparam logic [FUNSEL_W-1:0] FS_CMP = 4'b0110;
  localparam logic [FUNSEL_W-1:0] FS_AND = 4'b0111;
  localparam logic [FUNSEL_W-1:0] FS_OR  = 4'b1000;
  localparam logic [FUNSEL_W-1:0] FS_XOR = 4'b1010;
  localparam logic [FUNSEL_W-1:0] FS_LSL = 4'b1011;
  localparam logic [FUNSEL_W-1:0] FS_LSR = 4'b1100;
  localparam logic [FUNSEL_W-1:0] FS_ASL = 4'b1101;
  localparam logic [FUNSEL_W-1:0] FS_ASR = 4'b1110;
  localparam logic [FUNSEL_W-1:0] FS_CSR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant: one-hot, purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: arbitrate, drive the ALU inputs,
// wait for the registered flags, capture the result and hand it back.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FLAG_W = DEF_FLAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*FUNSEL_W-1:0] req_funsel,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [FLAG_W-1:0]     rsp_flags,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [FUNSEL_W-1:0]   alu_funsel,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [FLAG_W-1:0]     alu_flags,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on a transfer completing in the same cycle.

  state_e state, state_nxt;
  logic        prio;
  logic        g;
  logic [1:0]  grant;
  logic        win;
  logic        accept;

  logic [DATA_W-1:0]   win_a;
  logic [DATA_W-1:0]   win_b;
  logic [FUNSEL_W-1:0] win_funsel;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio),
    .grant (grant)
  );

  assign win        = grant[1];
  assign win_a      = win ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign win_b      = win ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign win_funsel = win ? req_funsel[2*FUNSEL_W-1:FUNSEL_W] : req_funsel[FUNSEL_W-1:0];

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign rsp_valid = (state == ST_RESP) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready[g]) state_nxt = ST_IDLE;
    endcase
  end

  // ALU inputs stay put after the operation so alu_out is still valid in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funsel <= '0;
      g          <= 1'b0;
      prio       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        alu_a      <= win_a;
        alu_b      <= win_b;
        alu_funsel <= win_funsel;
        g          <= win;
        prio       <= ~win;
      end
      if (state == ST_CAPTURE) begin
        rsp_result <= alu_out;
        rsp_flags  <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_funsel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_funsel;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags = 4'b0000;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  // Expected responses: {port, result, flags}
  logic [12:0] exp_q[$];

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_funsel (req_funsel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funsel (alu_funsel),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model: combinational result, flags {Z,C,N,O} registered
  logic [8:0] sum9;
  logic [7:0] r_c;
  logic       c_c, o_c;
  logic [3:0] flags_c;

  always_comb begin
    sum9 = 9'd0;
    r_c  = 8'h00;
    c_c  = 1'b0;
    o_c  = 1'b0;
    case (alu_funsel)
      FS_ADD: begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b};
        r_c  = sum9[7:0];
        c_c  = sum9[8];
        o_c  = (alu_a[7] == alu_b[7]) && (r_c[7] != alu_a[7]);
      end
      FS_SUB, FS_CMP: begin
        sum9 = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        r_c  = sum9[7:0];
        c_c  = sum9[8];
        o_c  = (alu_a[7] != alu_b[7]) && (r_c[7] != alu_a[7]);
      end
      FS_AND: r_c = alu_a & alu_b;
      FS_OR:  r_c = alu_a | alu_b;
      FS_XOR: r_c = alu_a ^ alu_b;
      FS_LSL, FS_ASL: begin r_c = {alu_a[6:0], 1'b0};      c_c = alu_a[7]; end
      FS_LSR: begin r_c = {1'b0, alu_a[7:1]};              c_c = alu_a[0]; end
      FS_ASR: begin r_c = {alu_a[7], alu_a[7:1]};          c_c = alu_a[0]; end
      FS_CSR: begin r_c = {alu_a[0], alu_a[7:1]};          c_c = alu_a[0]; end
      default: r_c = 8'h00;
    endcase
    flags_c = {(r_c == 8'h00), c_c, r_c[7], o_c};
  end

  assign alu_out = r_c;
  always @(posedge clk) alu_flags <= flags_c;

  // ---------------- checking helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input int p);
    logic [12:0] exp;
    check("sb_nonempty", (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("rsp_data", {rsp_valid[1], rsp_result, rsp_flags}, exp);
    end
    check("rsp_onehot", rsp_valid, (p == 1) ? 2'b10 : 2'b01);
  endtask

  // ---------------- driver tasks (drive at posedge+1, sample at negedge)
  task automatic set_req(input int p, input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
    req_a[p*8 +: 8]      = a;
    req_b[p*8 +: 8]      = b;
    req_funsel[p*4 +: 4] = fs;
    req_valid[p]         = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_grant);
    int cnt = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, req_ready, exp_grant);
  endtask

  task automatic wait_rsp(input int p);
    int cnt = 0;
    @(negedge clk);
    while (!rsp_valid[p] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rsp_arrived", rsp_valid[p], 1'b1);
    sb_compare(p);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence
  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_funsel = '0;
    rsp_ready  = 2'b00;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_in", {alu_a, alu_b, alu_funsel}, 20'h00000);
    check("rst_rsp", {rsp_result, rsp_flags}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request: port 0 ADD 0x33 + 0x0F
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    set_req(0, FS_ADD, 8'h33, 8'h0F);
    exp_q.push_back({1'b0, 8'h42, 4'b0000});
    @(negedge clk);
    check("single_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    busy_cnt = 0;
    @(negedge clk);
    busy_cnt += int'(busy);
    check("single_issue", state_dbg, ST_ISSUE);
    check("single_alu_in", {alu_a, alu_b, alu_funsel}, {8'h33, 8'h0F, FS_ADD});
    check("single_ready_issue", req_ready, 2'b00);
    check("single_rsp_issue", rsp_valid, 2'b00);
    @(negedge clk);
    busy_cnt += int'(busy);
    check("single_capture", state_dbg, ST_CAPTURE);
    check("single_rsp_capture", rsp_valid, 2'b00);
    @(negedge clk);
    busy_cnt += int'(busy);
    sb_compare(0);
    @(negedge clk);
    busy_cnt += int'(busy);
    check("single_back_idle", {state_dbg, rsp_valid}, {ST_IDLE, 2'b00});
    check("single_busy_cycles", busy_cnt, 3);

    // Contention after reset: prio 0 so port 0 first
    do_reset();
    set_req(0, FS_AND, 8'hAA, 8'hF0);
    set_req(1, FS_OR, 8'hAA, 8'hF0);
    wait_grant("cont_grant0", 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    exp_q.push_back({1'b0, 8'hA0, 4'b0010});
    wait_rsp(0);
    wait_grant("cont_grant1", 2'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    exp_q.push_back({1'b1, 8'hFA, 4'b0010});
    wait_rsp(1);

    // Fairness: both ports held valid for six operations
    @(posedge clk); #1;
    set_req(0, FS_XOR, 8'hAA, 8'hF0);
    set_req(1, FS_XOR, 8'hAA, 8'hF0);
    for (int k = 0; k < 6; k++) begin
      wait_grant("fair_grant", (k % 2 == 1) ? 2'b10 : 2'b01);
      exp_q.push_back({logic'(k % 2), 8'h5A, 4'b0000});
      wait_rsp(k % 2);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Back-pressure on port 1; port 0 ready is irrelevant while port 1 owns RESP
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    set_req(1, FS_LSL, 8'h33, 8'h00);
    wait_grant("bp_grant", 2'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, FS_ADD, 8'hFF, 8'h01);
    exp_q.push_back({1'b1, 8'h66, 4'b0000});
    wait_rsp(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {state_dbg, rsp_valid, rsp_result, req_ready}, {ST_RESP, 2'b10, 8'h66, 2'b00});
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_hs_cycle", {rsp_valid, req_ready}, {2'b10, 2'b00});
    @(negedge clk);
    check("bp_after", {state_dbg, rsp_valid, req_ready}, {ST_IDLE, 2'b00, 2'b01});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    exp_q.push_back({1'b0, 8'h00, 4'b1100});
    wait_rsp(0);

    // Reset in CAPTURE drops the operation
    @(posedge clk); #1;
    set_req(0, FS_OR, 8'h55, 8'h0F);
    wait_grant("mid_grant", 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_issue", state_dbg, ST_ISSUE);
    @(negedge clk);
    check("mid_capture", state_dbg, ST_CAPTURE);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {state_dbg, busy, req_ready, rsp_valid}, {ST_IDLE, 1'b0, 2'b00, 2'b00});
    check("mid_rst_alu", {alu_a, alu_b, alu_funsel}, 20'h00000);
    check("mid_rst_rsp", {rsp_result, rsp_flags}, 12'h000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_no_rsp_after", {rsp_valid, busy}, 3'b000);
    @(posedge clk); #1;
    set_req(1, FS_SUB, 8'h07, 8'hFA);
    wait_grant("sub_grant", 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    exp_q.push_back({1'b1, 8'h0D, 4'b0000});
    wait_rsp(1);

    // Undefined FunSel completes with whatever the ALU returns
    @(posedge clk); #1;
    set_req(0, 4'b1001, 8'h12, 8'h34);
    wait_grant("undef_grant", 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    exp_q.push_back({1'b0, 8'h00, 4'b1000});
    wait_rsp(0);

    // Operands remain on the ALU after completion
    @(posedge clk); #1;
    set_req(1, FS_CSR, 8'h80, 8'h00);
    wait_grant("csr_grant", 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    exp_q.push_back({1'b1, 8'h40, 4'b0000});
    wait_rsp(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stale_hold", {alu_a, alu_funsel, busy, state_dbg}, {8'h80, FS_CSR, 1'b0, ST_IDLE});
    end

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
